// File: rtl/mem_port_ctrl.sv
// Byte-wide memory port sequencer: one CPU access per request, req/ack handshake
// to memory, read-byte return and instruction-register lane loading. Option: MEMPORT_TIMEOUT_EN.
module mem_port_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [7:0]        cpu_wdata,
  input  logic [3:0]        irwrite,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_err,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] ir_sel;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_ctrl: TIMEOUT must be >= 1");
  end

`ifdef MEMPORT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT));
`else
  assign cpu_err = 1'b0;
`endif

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  // mem_we doubles as the captured direction; it only drops when leaving REQ
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ir_sel    <= 4'b0000;
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_rdata <= 8'h00;
      instr     <= 32'h0000_0000;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= 8'h00;
`ifdef MEMPORT_TIMEOUT_EN
      cpu_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      cpu_done <= 1'b0;
`ifdef MEMPORT_TIMEOUT_EN
      cpu_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef MEMPORT_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (cpu_req) begin
            state     <= REQ;
            cpu_busy  <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_adr   <= cpu_adr;
            mem_wdata <= cpu_wdata;
            ir_sel    <= irwrite;
          end
        end

        REQ: begin
          if (mem_ack) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            cpu_done <= 1'b1;
            if (!mem_we) begin
              cpu_rdata <= mem_rdata;
              for (int k = 0; k < 4; k++) begin
                if (ir_sel[k]) instr[8*k +: 8] <= mem_rdata;
              end
            end
`ifdef MEMPORT_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= 8'h00;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end

        DONE: begin
          state    <= IDLE;
          cpu_busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          cpu_busy <= 1'b0;
          mem_req  <= 1'b0;
          mem_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule
